fib_serial_gen: RTL
===================

Name: fib_serial_gen

Overview:
- Parametrised Fibonacci generator for the Fibonacci demo.
- Computes F(n) iteratively; each recurrence step is a bit-serial addition through a single one-bit full adder plus a carry register, LSB first, WIDTH cycles per step.
- Start/busy/done handshake and a sticky overflow flag. It is the sequential, width-generic successor of the combinational full-adder cell.

Parameters:
- WIDTH, 16: width of operands and result in bits; must be at least 2.
- N_W, 6: width of the index input n.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- n  input  N_W  Fibonacci index; captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse marking a valid result.
- result  output  WIDTH  F(n) mod 2^WIDTH; held until the next done.
- overflow  output  1  set if any step produced a carry-out; valid with done, held with result.

Behaviour:
- Reset: rst_n=0 at a rising edge forces state=IDLE, busy=0, done=0, result=0, overflow=0, and clears carry, bit counter and step counter.
  - Reset wins over everything, including mid-operation; an aborted operation never asserts done.
- Recurrence: F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2). All arithmetic is mod 2^WIDTH.
- States: IDLE, ADD, DONE.
- IDLE:
  - busy=0.
  - On an edge with start=1: capture n into n_reg, set a=0, b=1, carry=0, bit_cnt=0, step_cnt=n-1.
  - Next state is ADD if n>=2, otherwise DONE.
- ADD: busy=1. Each cycle processes one bit position:
  - sum_bit = a_bit ^ b_bit ^ carry.
  - carry <= majority(a_bit, b_bit, carry).
  - a and b rotate right by one; sum_bit shifts into the sum register at the MSB.
- End of step (bit_cnt==WIDTH-1):
  - a <= b (original value), b <= completed sum, carry <= 0, bit_cnt <= 0, step_cnt decrements.
  - If the final carry-out is 1, set the internal sticky ovf_acc. It is cleared when start is accepted.
  - The step containing the last bit of the final step transitions to DONE.
- DONE: one cycle only.
  - done=1, busy=1.
  - result = b for n>=2, 0 for n==0, 1 for n==1.
  - overflow = ovf_acc.
  - Next state is IDLE.
- result and overflow update only on the edge entering DONE and are stable from the done cycle until the next done or reset.
- Latency, counted from the edge that accepts start to the cycle in which done is high:
  - n>=2: (n-1)*WIDTH+1 cycles.
  - n<2: 1 cycle.
- start while busy=1, including the DONE cycle, is ignored: not queued, no effect. The earliest next accept is the first IDLE cycle after done.
- n at its maximum (2^N_W-1) is legal; the step counter is N_W bits wide, so there is no wrap.
- After an overflow the computation continues modulo 2^WIDTH; the result is still F(n) mod 2^WIDTH.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> busy=0, done=0, result=0, overflow=0 throughout. Release with start=0 -> module stays idle.
- Trivial cases, WIDTH=16: n=0 -> done one cycle after accept, result=0, overflow=0. n=1 -> result=1, overflow=0.
- Nominal case, WIDTH=16: n=10 -> done exactly 145 cycles after accept, result=55, overflow=0. n=24 -> result=46368, overflow=0.
- Overflow, WIDTH=16: n=25 -> result=9489 (75025 mod 65536), overflow=1. A following n=5 -> result=5, overflow=0 (sticky flag cleared on accept).
- WIDTH=8 instance: n=13 -> result=233, overflow=0, latency 97 cycles. n=14 -> result=121, overflow=1.
- Protocol and abort:
  - start pulsed during ADD and in the DONE cycle -> ignored, exactly one done.
  - rst_n=0 for one cycle mid-ADD -> no done, result=0; the next start n=7 -> 13.

Source files
------------

// File: rtl/fib_serial_gen_if.sv
// Handshake and result bundle for fib_serial_gen: the requester drives start/n,
// the generator answers with busy/done/result/overflow.
interface fib_serial_gen_if #(
    parameter int WIDTH = 16,
    parameter int N_W   = 6
);
    logic             start;
    logic [N_W-1:0]   n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;

    modport master (
        output start, n,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, n,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/fib_serial_gen.sv
// Iterative Fibonacci generator: each recurrence step is an LSB-first bit-serial
// add through one full adder and a carry flop, WIDTH cycles per step.
module fib_serial_gen #(
    parameter int WIDTH = 16,
    parameter int N_W   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    fib_serial_gen_if.slave bus
);
    localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [N_W-1:0]   step_cnt_q, step_cnt_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;

    logic             a_bit, b_bit, sum_bit, carry_out;
    logic [WIDTH-1:0] a_rot, b_rot, sum_shift;

    // The single full-adder cell; rotating a and b returns them to their
    // original values after WIDTH cycles, so b_rot on the last bit is the old b.
    assign a_bit     = a_q[0];
    assign b_bit     = b_q[0];
    assign sum_bit   = a_bit ^ b_bit ^ carry_q;
    assign carry_out = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
    assign a_rot     = {a_q[0], a_q[WIDTH-1:1]};
    assign b_rot     = {b_q[0], b_q[WIDTH-1:1]};
    assign sum_shift = {sum_bit, sum_q[WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        bit_cnt_d  = bit_cnt_q;
        step_cnt_d = step_cnt_q;
        ovf_acc_d  = ovf_acc_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d        = '0;
                    b_d        = WIDTH'(1);
                    sum_d      = '0;
                    carry_d    = 1'b0;
                    bit_cnt_d  = '0;
                    step_cnt_d = bus.n - N_W'(1);
                    ovf_acc_d  = 1'b0;
                    if (bus.n > N_W'(1)) begin
                        state_d = ST_ADD;
                    end else begin
                        state_d    = ST_DONE;
                        result_d   = (bus.n == '0) ? '0 : WIDTH'(1);
                        overflow_d = 1'b0;
                    end
                end
            end

            ST_ADD: begin
                a_d       = a_rot;
                b_d       = b_rot;
                sum_d     = sum_shift;
                carry_d   = carry_out;
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    a_d        = b_rot;
                    b_d        = sum_shift;
                    carry_d    = 1'b0;
                    bit_cnt_d  = '0;
                    step_cnt_d = step_cnt_q - N_W'(1);
                    ovf_acc_d  = ovf_acc_q | carry_out;
                    if (step_cnt_q == N_W'(1)) begin
                        state_d    = ST_DONE;
                        result_d   = sum_shift;
                        overflow_d = ovf_acc_q | carry_out;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            bit_cnt_q  <= '0;
            step_cnt_q <= '0;
            ovf_acc_q  <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            bit_cnt_q  <= bit_cnt_d;
            step_cnt_q <= step_cnt_d;
            ovf_acc_q  <= ovf_acc_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
endmodule
